// File: rtl/wb_mem_write_sequencer.sv
// Writeback memory-write sequencer: drains the wb&is_mem result slots of
// one retiring op onto a single write-request port, lowest slot first.
module wb_mem_write_sequencer #(
    parameter int NRES   = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NRES-1:0]          in_res_wb,
    input  logic [NRES-1:0]          in_res_is_mem,
    input  logic [NRES*DATA_W-1:0]   in_res,
    input  logic [NRES*ADDR_W-1:0]   in_res_dest,
    input  logic [1:0]               in_ressize,
    input  logic [6:0]               in_ptcid,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic [ADDR_W-1:0]        mem_req_addr,
    output logic [DATA_W-1:0]        mem_req_data,
    output logic [1:0]               mem_req_size,
    output logic [6:0]               mem_req_ptcid,
    output logic                     op_done,
    output logic [15:0]              mem_wr_cnt
);

    localparam int IDX_W = (NRES > 1) ? $clog2(NRES) : 1;

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    state_t                   state_q, state_d;
    logic [NRES-1:0]          mask_q, mask_d;
    logic [NRES*DATA_W-1:0]   res_q, res_d;
    logic [NRES*ADDR_W-1:0]   dest_q, dest_d;
    logic [1:0]               size_d;
    logic [6:0]               ptcid_d;
    logic                     valid_d;
    logic [ADDR_W-1:0]        addr_d;
    logic [DATA_W-1:0]        data_d;
    logic                     done_d;
    logic [15:0]              cnt_d;

    logic [NRES-1:0]          in_mask;
    logic [NRES-1:0]          rem_mask;
    logic [IDX_W-1:0]         in_idx;
    logic [IDX_W-1:0]         rem_idx;
    logic                     beat_acc;

    function automatic logic [IDX_W-1:0] low_idx(input logic [NRES-1:0] m);
        low_idx = '0;
        for (int i = NRES - 1; i >= 0; i--) begin
            if (m[i]) low_idx = IDX_W'(i);
        end
    endfunction

    function automatic logic [DATA_W-1:0] size_mask(
        input logic [DATA_W-1:0] d,
        input logic [1:0]        sz
    );
        int lim;
        lim = 8 << sz;
        size_mask = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < lim) size_mask[i] = d[i];
        end
    endfunction

    assign in_ready = (state_q == IDLE);
    assign in_mask  = in_res_wb & in_res_is_mem;
    // Clearing the lowest set bit retires the slot just accepted.
    assign rem_mask = mask_q & (mask_q - NRES'(1));
    assign in_idx   = low_idx(in_mask);
    assign rem_idx  = low_idx(rem_mask);
    assign beat_acc = mem_req_valid & mem_req_ready;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        res_d   = res_q;
        dest_d  = dest_q;
        size_d  = mem_req_size;
        ptcid_d = mem_req_ptcid;
        valid_d = mem_req_valid;
        addr_d  = mem_req_addr;
        data_d  = mem_req_data;
        done_d  = 1'b0;
        cnt_d   = mem_wr_cnt;

        // A beat handshaken on a flush edge still reached memory.
        if (beat_acc) cnt_d = mem_wr_cnt + 16'd1;

        if (flush) begin
            state_d = IDLE;
            mask_d  = '0;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        res_d   = in_res;
                        dest_d  = in_res_dest;
                        size_d  = in_ressize;
                        ptcid_d = in_ptcid;
                        mask_d  = in_mask;
                        if (in_mask == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = DRAIN;
                            valid_d = 1'b1;
                            addr_d  = in_res_dest[in_idx*ADDR_W +: ADDR_W];
                            data_d  = size_mask(
                                in_res[in_idx*DATA_W +: DATA_W], in_ressize);
                        end
                    end
                end
                DRAIN: begin
                    if (beat_acc) begin
                        mask_d = rem_mask;
                        if (rem_mask == '0) begin
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            addr_d = dest_q[rem_idx*ADDR_W +: ADDR_W];
                            data_d = size_mask(
                                res_q[rem_idx*DATA_W +: DATA_W], mem_req_size);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q       <= IDLE;
            mask_q        <= '0;
            res_q         <= '0;
            dest_q        <= '0;
            mem_req_size  <= '0;
            mem_req_ptcid <= '0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_data  <= '0;
            op_done       <= 1'b0;
            mem_wr_cnt    <= '0;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            res_q         <= res_d;
            dest_q        <= dest_d;
            mem_req_size  <= size_d;
            mem_req_ptcid <= ptcid_d;
            mem_req_valid <= valid_d;
            mem_req_addr  <= addr_d;
            mem_req_data  <= data_d;
            op_done       <= done_d;
            mem_wr_cnt    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_mem_write_sequencer.sv
// Bench for wb_mem_write_sequencer: vector table plus scoreboarded
// write beats, with hand sequences for stall, flush and async reset.
module tb_wb_mem_write_sequencer;

    logic         clk;
    logic         clr;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_res_wb;
    logic [3:0]   in_res_is_mem;
    logic [255:0] in_res;
    logic [127:0] in_res_dest;
    logic [1:0]   in_ressize;
    logic [6:0]   in_ptcid;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [31:0]  mem_req_addr;
    logic [63:0]  mem_req_data;
    logic [1:0]   mem_req_size;
    logic [6:0]   mem_req_ptcid;
    logic         op_done;
    logic [15:0]  mem_wr_cnt;

    wb_mem_write_sequencer dut (
        .clk           (clk),
        .clr           (clr),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_res_wb     (in_res_wb),
        .in_res_is_mem (in_res_is_mem),
        .in_res        (in_res),
        .in_res_dest   (in_res_dest),
        .in_ressize    (in_ressize),
        .in_ptcid      (in_ptcid),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_data  (mem_req_data),
        .mem_req_size  (mem_req_size),
        .mem_req_ptcid (mem_req_ptcid),
        .op_done       (op_done),
        .mem_wr_cnt    (mem_wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [63:0] data;
        logic [1:0]  size;
        logic [6:0]  ptcid;
    } beat_t;

    typedef struct {
        logic [3:0]   wb;
        logic [3:0]   mem;
        logic [255:0] d;
        logic [127:0] a;
        logic [1:0]   sz;
        logic [6:0]   id;
        int           nb;
    } vec_t;

    beat_t sb[$];
    int    n_cmp;
    int    n_err;
    int    exp_cnt;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] trunc(input logic [63:0] d,
                                          input logic [1:0] sz);
        case (sz)
            2'b00:   return d & 64'h0000_0000_0000_00FF;
            2'b01:   return d & 64'h0000_0000_0000_FFFF;
            2'b10:   return d & 64'h0000_0000_FFFF_FFFF;
            default: return d;
        endcase
    endfunction

    task automatic drive_op(input vec_t v, input bit push);
        beat_t b;
        @(posedge clk);
        #1;
        in_res_wb     = v.wb;
        in_res_is_mem = v.mem;
        in_res        = v.d;
        in_res_dest   = v.a;
        in_ressize    = v.sz;
        in_ptcid      = v.id;
        in_valid      = 1'b1;
        if (push) begin
            for (int i = 0; i < 4; i++) begin
                if (v.wb[i] && v.mem[i]) begin
                    b.addr  = v.a[i*32 +: 32];
                    b.data  = trunc(v.d[i*64 +: 64], v.sz);
                    b.size  = v.sz;
                    b.ptcid = v.id;
                    sb.push_back(b);
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid      = 1'b0;
        in_res        = {$urandom, $urandom, $urandom, $urandom,
                         $urandom, $urandom, $urandom, $urandom};
        in_res_dest   = {$urandom, $urandom, $urandom, $urandom};
        in_res_wb     = 4'($urandom);
        in_res_is_mem = 4'($urandom);
        in_ressize    = 2'($urandom);
        in_ptcid      = 7'($urandom);
    endtask

    always @(negedge clk) begin
        if (clr && mem_req_valid && mem_req_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_beat: unexpected beat addr %h", mem_req_addr);
            end else begin
                chk("sb_beat", {mem_req_addr, mem_req_data, mem_req_size,
                                mem_req_ptcid}, sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    vec_t vecs[5];
    vec_t v;
    int   lat;

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        exp_cnt       = 0;
        clr           = 1'b0;
        flush         = 1'b0;
        in_valid      = 1'b0;
        in_res_wb     = '0;
        in_res_is_mem = '0;
        in_res        = '0;
        in_res_dest   = '0;
        in_ressize    = '0;
        in_ptcid      = '0;
        mem_req_ready = 1'b1;

        vecs[0] = '{4'b1111, 4'b0000, {4{64'h1111_2222_3333_4444}},
                    {32'h40, 32'h30, 32'h20, 32'h10}, 2'b11, 7'h01, 0};
        vecs[1] = '{4'b1011, 4'b1011,
                    {64'hA3A3_A3A3_A3A3_A3A3, 64'hFFFF_FFFF_FFFF_FFFF,
                     64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0},
                    {32'h118, 32'h110, 32'h108, 32'h100}, 2'b11, 7'h12, 3};
        vecs[2] = '{4'b1111, 4'b0100,
                    {64'h5, 64'hDEAD_BEEF_CAFE_F00D, 64'h3, 64'h2},
                    {32'h3000, 32'h2000, 32'h1000, 32'h0}, 2'b01, 7'h33, 1};
        vecs[3] = '{4'b0110, 4'b1110,
                    {64'h0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                     64'h0}, {32'hC, 32'h8, 32'h4, 32'h0}, 2'b00, 7'h7F, 2};
        vecs[4] = '{4'b1111, 4'b1111,
                    {64'h4444_4444_8765_4321, 64'h3333_3333_1234_5678,
                     64'h2222_2222_0BAD_F00D, 64'h1111_1111_DEAD_BEEF},
                    {32'hFFFF_FFFC, 32'h0000_0002, 32'h8000_0001,
                     32'h0000_0000}, 2'b10, 7'h40, 4};

        #3;
        chk("rst_valid", mem_req_valid, 1'b0);
        chk("rst_done", op_done, 1'b0);
        chk("rst_cnt", mem_wr_cnt, 16'd0);
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_addr_data", {mem_req_addr, mem_req_data}, 96'd0);
        #9;
        clr = 1'b1;

        for (int n = 0; n < 5; n++) begin
            drive_op(vecs[n], 1'b1);
            lat = 0;
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                if (k <= vecs[n].nb) chk("drain_in_ready", in_ready, 1'b0);
                if (op_done) begin
                    lat = k;
                    break;
                end
            end
            exp_cnt += vecs[n].nb;
            chk($sformatf("v%0d_done_lat", n), lat, vecs[n].nb + 1);
            chk($sformatf("v%0d_in_ready", n), in_ready, 1'b1);
            chk($sformatf("v%0d_cnt", n), mem_wr_cnt, exp_cnt[15:0]);
            chk($sformatf("v%0d_sb_empty", n), sb.size(), 0);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", n), op_done, 1'b0);
        end

        // Backpressure on a single slot.
        mem_req_ready = 1'b0;
        v = '{4'b0100, 4'b0100,
              {64'h0, 64'h0123_4567_89AB_CDEF, 64'h0, 64'h0},
              {32'h0, 32'h2000, 32'h0, 32'h0}, 2'b10, 7'h05, 1};
        drive_op(v, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", mem_req_valid, 1'b1);
            chk("bp_addr", mem_req_addr, 32'h2000);
            chk("bp_data", mem_req_data, 64'h0000_0000_89AB_CDEF);
            chk("bp_in_ready", in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk("bp_addr_last", mem_req_addr, 32'h2000);
        chk("bp_in_ready_last", in_ready, 1'b0);
        @(negedge clk);
        exp_cnt += 1;
        chk("bp_done", op_done, 1'b1);
        chk("bp_valid_off", mem_req_valid, 1'b0);
        chk("bp_cnt", mem_wr_cnt, exp_cnt[15:0]);

        // Flush on the second beat's accept edge.
        v = vecs[4];
        drive_op(v, 1'b1);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        exp_cnt += 2;
        chk("fl_valid", mem_req_valid, 1'b0);
        chk("fl_in_ready", in_ready, 1'b1);
        chk("fl_cnt", mem_wr_cnt, exp_cnt[15:0]);
        chk("fl_sb_left", sb.size(), 2);
        sb.delete();
        for (int k = 0; k < 3; k++) begin
            chk("fl_no_done", op_done, 1'b0);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a drain.
        mem_req_ready = 1'b0;
        drive_op(vecs[4], 1'b0);
        @(negedge clk);
        chk("t1_pre_valid", mem_req_valid, 1'b1);
        @(negedge clk);
        #2;
        clr = 1'b0;
        #1;
        chk("t1_valid", mem_req_valid, 1'b0);
        chk("t1_done", op_done, 1'b0);
        chk("t1_cnt", mem_wr_cnt, 16'd0);
        chk("t1_in_ready", in_ready, 1'b1);
        @(negedge clk);
        clr = 1'b1;
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk("t1_post_valid", mem_req_valid, 1'b0);
        chk("t1_post_cnt", mem_wr_cnt, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
